rom_2kx32_arbiter: RTL and testbench
====================================

// Module: rom_2kx32_arbiter
// PURPOSE
//  Shares the single-port ROM_2KX32BIT macro (Q, CLK, CEN, A) between NREQ read requesters.
//  Arbitrates round-robin or fixed-priority and drives CEN/A, then returns read data tagged to the owner.
//  The macro's output bank mux is Q = DO[A[10:9]] on the *live* A, so this block must hold A's bank bits through each data phase.
//  Sits between fetch/data read units and the ROM instance.
// PARAMETERS
//  NREQ      2   number of requesters (2..8)
//  AW        11  ROM word-address width
//  DW        32  ROM data width
//  BANK_LSB  9   lowest address bit of the bank select (bank = A[AW-1:BANK_LSB])
//  RR_EN     1   1 = round-robin, 0 = fixed priority (index 0 highest)
// PORTS
//  CLK        in   1        single clock
//  RSTN       in   1        asynchronous active-low reset
//  req_i      in   NREQ     per-requester read request; held with addr until accepted
//  addr_i     in   NREQ*AW  packed word addresses; requester k at [k*AW +: AW]
//  gnt_o      out  NREQ     combinational accept; transfer when req_i[k] & gnt_o[k] at CLK rise
//  rvalid_o   out  NREQ     one-hot, 1-cycle pulse: rdata_o belongs to requester k
//  rdata_o    out  DW       registered read data
//  rom_cen_o  out  1        to ROM CEN (active low)
//  rom_a_o    out  AW       to ROM A (registered)
//  rom_q_i    in   DW       from ROM Q
// BEHAVIOUR
//  Reset (async, RSTN=0): rom_cen_o=1, rom_a_o=0, gnt_o=0, rvalid_o=0, rdata_o=0, rr pointer=NREQ-1, pipeline flags clear.
//  Pipeline per access: accept edge E0 -> ISSUE cycle [E0,E1): rom_cen_o=0, rom_a_o=addr
//   -> DATA cycle [E1,E2): ROM DO valid, rom_q_i sampled at E2 -> rvalid_o[k]=1, rdata_o=Q during [E2,E3).
//  Latency: accept edge to rvalid_o = 2 clocks. Throughput: 1 access/clock.
//  rom_cen_o=1 in every cycle with no ISSUE; rom_a_o changes only on accept, otherwise holds last value.
//  Arbitration: winner = first requesting index after rr pointer (RR_EN=1) or lowest requesting index (RR_EN=0).
//   At most one gnt_o bit high; gnt_o=0 when no req_i.
//   Pointer updates to the winner only on a transfer.
//  Bank hazard rule: in a cycle where rom_cen_o=0 (next cycle is that access's DATA), the winner is granted only if
//   addr bank == rom_a_o bank. On mismatch: gnt_o=0 (one bubble), winner unchanged; it is granted the following cycle.
//   Never skip to a lower-priority same-bank requester (no starvation).
//  Requester protocol: addr_i[k] stable while req_i[k]=1 and not yet accepted; may drop req_i before accept (no access occurs).
//  Same requester may be accepted on consecutive cycles; responses return in accept order, one per cycle.
//  Mid-operation reset: all in-flight accesses discarded; no rvalid_o after RSTN release until a new accept.
//  Width rules: bank compare uses bits [AW-1:BANK_LSB] only; no address arithmetic; ROM addresses >= 2**AW unreachable.
// STRUCTURE
//  Shared package rom_arb_pkg: AW/DW/BANK_LSB constants, NREQ max, owner-index width localparam, bank_of() function.
//  Sub-module rr_arbiter (req vector + pointer + RR_EN -> one-hot winner, combinational); reused elsewhere.
//  Top: accept logic + hazard compare, ISSUE/DATA valid+owner shift registers, rom_a_o/rdata_o registers.
// TESTING
//  1 Single: req_i[0]=1, addr 0x005 -> gnt_o[0] same cycle; next cycle cen=0,A=0x005; rvalid_o[0] 2 clks after accept, rdata=ROM[5].
//  2 Same bank b2b: req0 0x010, req1 0x011 held -> accepts on consecutive edges, no bubble; rvalid_o 01 then 10, data ROM[0x10],ROM[0x11].
//  3 Bank cross: req0 0x1FF then req0 0x200 -> exactly one cen=1 bubble; rdata ROM[0x1FF] then ROM[0x200] (bank1), never bank0 word.
//  4 Fairness: both requesters held, same bank, RR_EN=1 -> grants 0,1,0,1...; RR_EN=0 -> only 0 granted while req_i[0]=1.
//  5 Reset mid-op: RSTN low during DATA cycle -> cen=1, rvalid=0 immediately; after release, no stray rvalid_o for 4 clocks.
//  6 Idle/withdraw: req raised then dropped while bank-stalled -> no access issued, rom_a_o holds, cen stays 1.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared constants, owner/bank types and the bank-select helper for the ROM_2KX32BIT arbiter.
// Types and constants only; there is no timing or flow control here.
package rom_arb_pkg;
  localparam int AW_C       = 11;
  localparam int DW_C       = 32;
  localparam int BANK_LSB_C = 9;
  localparam int NREQ_MAX   = 8;
  localparam int OWNER_W    = $clog2(NREQ_MAX);
  localparam int BANK_W     = AW_C - BANK_LSB_C;

  typedef logic [OWNER_W-1:0] owner_t;
  typedef logic [BANK_W-1:0]  bank_t;

  function automatic bank_t bank_of(input logic [AW_C-1:0] a);
    return a[AW_C-1:BANK_LSB_C];
  endfunction
endpackage

// File: rtl/rom_2kx32_arbiter_if.sv
// Requester-side bus of the ROM arbiter: per-requester requests and addresses in, grants and tagged read data out.
// Grants are combinational; a requester holds req_i and its address until it sees gnt_o.
interface rom_2kx32_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 11,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    rvalid_o;
  logic [DW-1:0]      rdata_o;

  modport master (output req_i, addr_i, input gnt_o, rvalid_o, rdata_o);
  modport slave  (input req_i, addr_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot winner: first requester above ptr_i (wrapping) or lowest index when rr_en_i=0.
// Zero latency; no state, so the caller owns the pointer and decides when to advance it.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          rr_en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] above;
  logic [N-1:0] cand;

  always_comb begin
    above = '0;
    for (int k = 0; k < N; k++) begin
      above[k] = req_i[k] && (k > int'(ptr_i));
    end
    // Requesters above the pointer win first; otherwise wrap to the lowest index.
    cand  = (rr_en_i && (above != '0)) ? above : req_i;
    gnt_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/rom_2kx32_arbiter.sv
// Shares one ROM_2KX32BIT among NREQ readers; accept -> ISSUE -> DATA, tagged rvalid_o 2 clocks after accept, 1 access/clock.
// Backpressure: gnt_o withheld for one cycle when the winner's bank differs from the bank the ROM is still outputting.
module rom_2kx32_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = AW_C,
  parameter int DW       = DW_C,
  parameter int BANK_LSB = BANK_LSB_C,
  parameter bit RR_EN    = 1'b1
) (
  input  logic                CLK,
  input  logic                RSTN,
  rom_2kx32_arbiter_if.slave  bus,
  output logic                rom_cen_o,
  output logic [AW-1:0]       rom_a_o,
  input  logic [DW-1:0]       rom_q_i
);
  owner_t          ptr_q,     ptr_d;
  logic            iss_vld_q, iss_vld_d;
  owner_t          iss_own_q, iss_own_d;
  logic            dat_vld_q, dat_vld_d;
  owner_t          dat_own_q, dat_own_d;
  logic [AW-1:0]   rom_a_q,   rom_a_d;
  logic [NREQ-1:0] rvalid_q,  rvalid_d;
  logic [DW-1:0]   rdata_q,   rdata_d;

  logic [NREQ-1:0] win_gnt;
  owner_t          win_idx;
  logic            win_any;
  logic [AW-1:0]   win_addr;
  logic            bank_hit;
  logic            grant_ok;

  rr_arbiter #(
    .N  (NREQ),
    .IW (OWNER_W)
  ) u_arb (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .rr_en_i (RR_EN),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    win_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_gnt[k]) win_addr = bus.addr_i[k*AW +: AW];
    end
    // The ROM's output mux follows the live A, so A's bank must not move while a prior access is in its DATA cycle.
    bank_hit = (win_addr[AW-1:BANK_LSB] == rom_a_q[AW-1:BANK_LSB]);
    grant_ok = RSTN && win_any && (!iss_vld_q || bank_hit);
  end

  always_comb begin
    iss_vld_d = grant_ok;
    iss_own_d = grant_ok ? win_idx : iss_own_q;
    rom_a_d   = grant_ok ? win_addr : rom_a_q;
    ptr_d     = grant_ok ? win_idx : ptr_q;
    dat_vld_d = iss_vld_q;
    dat_own_d = iss_own_q;
    rvalid_d  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rvalid_d[k] = dat_vld_q && (dat_own_q == OWNER_W'(k));
    end
    rdata_d = dat_vld_q ? rom_q_i : rdata_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q     <= OWNER_W'(NREQ - 1);
      iss_vld_q <= 1'b0;
      iss_own_q <= '0;
      dat_vld_q <= 1'b0;
      dat_own_q <= '0;
      rom_a_q   <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      iss_vld_q <= iss_vld_d;
      iss_own_q <= iss_own_d;
      dat_vld_q <= dat_vld_d;
      dat_own_q <= dat_own_d;
      rom_a_q   <= rom_a_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.gnt_o    = grant_ok ? win_gnt : '0;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign rom_cen_o    = ~iss_vld_q;
  assign rom_a_o      = rom_a_q;
endmodule

// File: tb/tb_rom_2kx32_arbiter.sv
// Bench: banked ROM model with a live-A output mux, queue-fed requesters, accept-time scoreboard and negedge monitor.
// A second instance with fixed priority shares the request stimulus for the priority check.
module tb_rom_2kx32_arbiter;
  import rom_arb_pkg::*;

  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_2kx32_arbiter_if #(.NREQ(NR), .AW(11), .DW(32)) bus ();
  rom_2kx32_arbiter_if #(.NREQ(NR), .AW(11), .DW(32)) fp_bus ();

  logic        rom_cen, fp_cen;
  logic [10:0] rom_a, fp_a;
  logic [31:0] rom_q;

  rom_2kx32_arbiter #(.NREQ(NR), .RR_EN(1'b1)) dut (
    .CLK(clk), .RSTN(rst_n), .bus(bus),
    .rom_cen_o(rom_cen), .rom_a_o(rom_a), .rom_q_i(rom_q)
  );

  rom_2kx32_arbiter #(.NREQ(NR), .RR_EN(1'b0)) dut_fp (
    .CLK(clk), .RSTN(rst_n), .bus(fp_bus),
    .rom_cen_o(fp_cen), .rom_a_o(fp_a), .rom_q_i(32'h0)
  );

  assign fp_bus.req_i  = bus.req_i;
  assign fp_bus.addr_i = bus.addr_i;

  function automatic logic [31:0] rom_word(input logic [10:0] a);
    return {5'h15, a, 5'h0A, a};
  endfunction

  // Each bank keeps its own DO; Q follows the bank bits of the live A.
  logic [31:0] do_b [4] = '{default: 32'h0};
  always @(posedge clk) if (!rom_cen) do_b[rom_a[10:9]] <= rom_word(rom_a);
  assign rom_q = do_b[rom_a[10:9]];

  int total = 0;
  int bad = 0;
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  own;
    logic [31:0] dat;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  int          glog[$];
  int          gcyc[$];
  logic [10:0] pend0[$];
  logic [10:0] pend1[$];
  int          cyc = 0;
  logic [1:0]  took = 2'b00;
  logic [10:0] a_prev = '0;
  bit          fp_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accept tracker plus per-cycle protocol checks.
  always @(negedge clk) begin
    logic [1:0]  g, r;
    logic [10:0] ga;
    if (!rst_n) begin
      took   = 2'b00;
      a_prev = rom_a;
    end else begin
      g = bus.gnt_o;
      r = bus.req_i;
      chk(rom_cen == !(|took), "cen_vs_accept", 32'(rom_cen), 32'(!(|took)));
      if (rom_a != a_prev) chk(|took, "a_moves_only_on_accept", 32'(rom_a), 32'(a_prev));
      chk(((g & (g - 2'd1)) == 2'b00) && ((g & ~r) == 2'b00), "gnt_onehot_subset", 32'(g), 32'(r));
      for (int k = 0; k < NR; k++) begin
        if (g[k] && r[k]) begin
          ga = bus.addr_i[k*11 +: 11];
          if (!rom_cen) chk(bank_of(ga) == bank_of(rom_a), "bank_hazard", 32'(ga), 32'(rom_a));
          sb.push_back('{own: 3'(k), dat: rom_word(ga), due: 32'(cyc + 3)});
          glog.push_back(k);
          gcyc.push_back(cyc);
        end
      end
      if (fp_chk && r[0]) chk(fp_bus.gnt_o == 2'b01, "fixed_prio_gnt", 32'(fp_bus.gnt_o), 32'h1);
      took   = g & r;
      a_prev = rom_a;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rvalid_o != 2'b00) begin
        if (sb.size() == 0) begin
          chk(1'b0, "stray_rvalid", 32'(bus.rvalid_o), 32'h0);
        end else begin
          e = sb.pop_front();
          chk(bus.rvalid_o == (2'b01 << e.own), "rvalid_owner", 32'(bus.rvalid_o), 32'(2'b01 << e.own));
          chk(bus.rdata_o == e.dat, "rdata", bus.rdata_o, e.dat);
          chk(cyc == e.due, "latency", 32'(cyc), e.due);
        end
      end else if (sb.size() > 0 && cyc > int'(sb[0].due)) begin
        chk(1'b0, "missing_rvalid", 32'(cyc), sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  // Requester model: after an accept present the next queued address or drop the request.
  initial forever begin
    @(posedge clk);
    #1;
    if (took[0]) begin
      if (pend0.size() > 0) bus.addr_i[10:0] = pend0.pop_front();
      else bus.req_i[0] = 1'b0;
    end else if (!bus.req_i[0] && pend0.size() > 0) begin
      bus.addr_i[10:0] = pend0.pop_front();
      bus.req_i[0] = 1'b1;
    end
    if (took[1]) begin
      if (pend1.size() > 0) bus.addr_i[21:11] = pend1.pop_front();
      else bus.req_i[1] = 1'b0;
    end else if (!bus.req_i[1] && pend1.size() > 0) begin
      bus.addr_i[21:11] = pend1.pop_front();
      bus.req_i[1] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || bus.req_i != 2'b00 || sb.size() > 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk(n < 60, "idle_timeout", 32'(n), 32'd60);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bus.req_i  = '0;
    bus.addr_i = '0;
    repeat (2) @(negedge clk);
    bus.addr_i[10:0] = 11'h123;
    bus.req_i[0] = 1'b1;
    #1;
    chk(rom_cen == 1'b1, "rst_cen", 32'(rom_cen), 32'h1);
    chk(rom_a == 11'h0, "rst_a", 32'(rom_a), 32'h0);
    chk(bus.gnt_o == 2'b00, "rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk(bus.rvalid_o == 2'b00, "rst_rvalid", 32'(bus.rvalid_o), 32'h0);
    chk(bus.rdata_o == 32'h0, "rst_rdata", bus.rdata_o, 32'h0);
    bus.req_i = '0;
    step();
    rst_n = 1'b1;
    step();

    // Same-bank back-to-back: pointer starts at NREQ-1, so requester 0 wins first.
    glog.delete(); gcyc.delete();
    pend0.push_back(11'h010);
    pend1.push_back(11'h011);
    wait_idle();
    chk(glog.size() == 2 && glog[0] == 0 && glog[1] == 1, "b2b_order", 32'(glog.size()), 32'h2);
    chk(gcyc.size() == 2 && gcyc[1] == gcyc[0] + 1, "b2b_no_bubble", 32'(gcyc.size()), 32'h2);

    // Single access and its pipeline phases.
    step();
    bus.addr_i[10:0] = 11'h005;
    bus.req_i[0] = 1'b1;
    @(negedge clk);
    chk(bus.gnt_o == 2'b01, "single_gnt", 32'(bus.gnt_o), 32'h1);
    step();
    chk(rom_cen == 1'b0 && rom_a == 11'h005, "single_issue", {20'h0, rom_cen, rom_a}, 32'h005);
    step();
    chk(rom_cen == 1'b1, "single_data_cen", 32'(rom_cen), 32'h1);
    wait_idle();

    // Bank crossing: 0x1FF (bank0) then 0x200 (bank1) must see exactly one bubble.
    glog.delete(); gcyc.delete();
    pend0.push_back(11'h1FF);
    pend0.push_back(11'h200);
    wait_idle();
    chk(gcyc.size() == 2 && gcyc[1] == gcyc[0] + 2, "bank_cross_one_bubble", 32'(gcyc.size()), 32'h2);

    // Fairness: both held in bank 0; round robin alternates, fixed priority only grants 0.
    glog.delete(); gcyc.delete();
    fp_chk = 1'b1;
    pend0.push_back(11'h020); pend0.push_back(11'h021); pend0.push_back(11'h022);
    pend1.push_back(11'h030); pend1.push_back(11'h031); pend1.push_back(11'h032);
    wait_idle();
    fp_chk = 1'b0;
    chk(glog.size() == 6, "rr_count", 32'(glog.size()), 32'h6);
    if (glog.size() == 6) begin
      for (int i = 1; i < 6; i++) begin
        chk(glog[i] != glog[i-1] && gcyc[i] == gcyc[i-1] + 1, "rr_alternate", 32'(glog[i]), 32'(1 - glog[i-1]));
      end
    end

    // Withdraw while bank-stalled: no access, A holds, CEN stays high.
    step();
    bus.addr_i[10:0] = 11'h004;
    bus.req_i[0] = 1'b1;
    step();
    bus.addr_i[21:11] = 11'h600;
    bus.req_i[1] = 1'b1;
    @(negedge clk);
    chk(bus.gnt_o == 2'b00 && rom_cen == 1'b0, "withdraw_stalled", 32'(bus.gnt_o), 32'h0);
    #1;
    bus.req_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(rom_cen == 1'b1 && rom_a == 11'h004, "withdraw_hold", {20'h0, rom_cen, rom_a}, 32'h804);
    end
    wait_idle();

    // Reset during a DATA cycle discards the access.
    step();
    bus.addr_i[10:0] = 11'h040;
    bus.req_i[0] = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk(rom_cen == 1'b1, "midrst_cen", 32'(rom_cen), 32'h1);
    chk(bus.rvalid_o == 2'b00, "midrst_rvalid", 32'(bus.rvalid_o), 32'h0);
    chk(rom_a == 11'h0, "midrst_a", 32'(rom_a), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(bus.rvalid_o == 2'b00, "post_rst_quiet", 32'(bus.rvalid_o), 32'h0);
    end
    wait_idle();

    chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
